// File: rtl/usr_btn_debounce_if.sv
// Raw button input and debounced event outputs of usr_btn_debounce.
// master drives the raw button; slave is the debouncer producing level and strobes.
interface usr_btn_debounce_if;
  logic usr_btn;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic short_press;
  logic long_press;

  modport master (
    output usr_btn,
    input  btn_level,
    input  press_pulse,
    input  release_pulse,
    input  short_press,
    input  long_press
  );

  modport slave (
    input  usr_btn,
    output btn_level,
    output press_pulse,
    output release_pulse,
    output short_press,
    output long_press
  );
endinterface

// File: rtl/usr_btn_debounce.sv
// Button debouncer: 2-flop synchronizer, press/release debounce FSM, short/long-press detection.
// Press strobe lands DEBOUNCE_CYCLES+2 edges after the first low sample; all strobes are registered.
module usr_btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES   = 480000,
  parameter int unsigned LONG_PRESS_CYCLES = 96000000
) (
  input logic              clk,
  input logic              rst_n,
  usr_btn_debounce_if.slave btn
);

  localparam logic [26:0] DB_LAST   = 27'(DEBOUNCE_CYCLES - 1);
  localparam logic [26:0] HOLD_LAST = 27'(LONG_PRESS_CYCLES - 1);
  localparam logic [26:0] HOLD_MAX  = '1;

  typedef enum logic [2:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    LONG_HELD,
    RELEASE_WAIT
  } state_t;

  state_t      state, state_nxt;
  logic        sync_1, btn_s;
  logic [26:0] db_cnt, db_cnt_nxt, db_inc;
  logic [26:0] hold_cnt, hold_cnt_nxt, hold_inc;
  logic        from_long, from_long_nxt;
  logic        level_q, press_q, release_q, short_q, long_q;
  logic        level_nxt, press_nxt, release_nxt, short_nxt, long_nxt;

  // Synchronizer idles at 1 so a reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b1;
      btn_s  <= 1'b1;
    end else begin
      sync_1 <= btn.usr_btn;
      btn_s  <= sync_1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RELEASED;
      db_cnt    <= '0;
      hold_cnt  <= '0;
      from_long <= 1'b0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      db_cnt    <= db_cnt_nxt;
      hold_cnt  <= hold_cnt_nxt;
      from_long <= from_long_nxt;
      level_q   <= level_nxt;
      press_q   <= press_nxt;
      release_q <= release_nxt;
      short_q   <= short_nxt;
      long_q    <= long_nxt;
    end
  end

  assign db_inc   = db_cnt + 27'd1;
  assign hold_inc = hold_cnt + 27'd1;

  // The sample that leaves a stable state counts as the first debounce sample,
  // hence the compare on the incremented value.
  always_comb begin
    state_nxt     = state;
    db_cnt_nxt    = db_cnt;
    hold_cnt_nxt  = hold_cnt;
    from_long_nxt = from_long;
    press_nxt     = 1'b0;
    release_nxt   = 1'b0;
    short_nxt     = 1'b0;
    long_nxt      = 1'b0;
    case (state)
      RELEASED: begin
        hold_cnt_nxt = '0;
        if (!btn_s) begin
          state_nxt  = PRESS_WAIT;
          db_cnt_nxt = '0;
        end
      end
      PRESS_WAIT: begin
        if (btn_s) begin
          state_nxt = RELEASED;
        end else if (db_inc == DB_LAST) begin
          state_nxt    = PRESSED;
          press_nxt    = 1'b1;
          hold_cnt_nxt = '0;
        end else begin
          db_cnt_nxt = db_inc;
        end
      end
      PRESSED: begin
        if (btn_s) begin
          state_nxt     = RELEASE_WAIT;
          from_long_nxt = 1'b0;
          db_cnt_nxt    = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nxt = LONG_HELD;
          long_nxt  = 1'b1;
        end else begin
          hold_cnt_nxt = hold_inc;
        end
      end
      LONG_HELD: begin
        if (btn_s) begin
          state_nxt     = RELEASE_WAIT;
          from_long_nxt = 1'b1;
          db_cnt_nxt    = '0;
        end else if (hold_cnt != HOLD_MAX) begin
          hold_cnt_nxt = hold_inc;
        end
      end
      RELEASE_WAIT: begin
        if (!btn_s) begin
          // Release bounce: resume the hold where it was frozen, this low sample included.
          if (from_long) begin
            state_nxt = LONG_HELD;
            if (hold_cnt != HOLD_MAX) hold_cnt_nxt = hold_inc;
          end else if (hold_cnt == HOLD_LAST) begin
            state_nxt = LONG_HELD;
            long_nxt  = 1'b1;
          end else begin
            state_nxt    = PRESSED;
            hold_cnt_nxt = hold_inc;
          end
        end else if (db_inc == DB_LAST) begin
          state_nxt    = RELEASED;
          release_nxt  = 1'b1;
          short_nxt    = !from_long;
          hold_cnt_nxt = '0;
        end else begin
          db_cnt_nxt = db_inc;
        end
      end
      default: begin
        state_nxt = RELEASED;
      end
    endcase
    level_nxt = (state_nxt == PRESSED) || (state_nxt == LONG_HELD) ||
                (state_nxt == RELEASE_WAIT);
  end

  assign btn.btn_level     = level_q;
  assign btn.press_pulse   = press_q;
  assign btn.release_pulse = release_q;
  assign btn.short_press   = short_q;
  assign btn.long_press    = long_q;

endmodule

// File: tb/tb_usr_btn_debounce.sv
// Directed bench for usr_btn_debounce with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20.
module tb_usr_btn_debounce;
  localparam int DB = 4;
  localparam int LP = 20;

  logic clk = 1'b0;
  logic rst_n;
  usr_btn_debounce_if bi();

  usr_btn_debounce #(.DEBOUNCE_CYCLES(DB), .LONG_PRESS_CYCLES(LP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (bi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       btn;
    logic [4:0] exp;   // {level, press, release, short, long}
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   n_press, n_release, n_short, n_long, n_b2b;
  int   t_press, t_release, t_long;
  logic prev_pulse = 1'b0;
  int   c0, p0, r0;

  function automatic logic [4:0] outs();
    return {bi.btn_level, bi.press_pulse, bi.release_pulse, bi.short_press, bi.long_press};
  endfunction

  task automatic add(input logic b, input logic [4:0] e);
    vec_t v;
    v.btn = b;
    v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic clr_log();
    n_press = 0; n_release = 0; n_short = 0; n_long = 0;
    t_press = -1; t_release = -1; t_long = -1;
  endtask

  // Drive the button, take one rising edge, then sample and log strobes.
  task automatic step(input logic b);
    logic cur;
    bi.usr_btn = b;
    @(posedge clk);
    #1;
    cyc++;
    if (bi.press_pulse)   begin n_press++;   t_press = cyc;   end
    if (bi.release_pulse) begin n_release++; t_release = cyc; end
    if (bi.short_press)   n_short++;
    if (bi.long_press)    begin n_long++;    t_long = cyc;    end
    cur = bi.press_pulse | bi.release_pulse | bi.short_press | bi.long_press;
    if (cur && prev_pulse) n_b2b++;
    prev_pulse = cur;
  endtask

  initial begin
    n_b2b = 0;
    clr_log();
    rst_n = 1'b0;
    bi.usr_btn = 1'b1;
    repeat (3) step(1'b1);
    check("reset_outs", int'(outs()), 0);
    rst_n = 1'b1;

    // Clean press, 10-cycle hold, clean release.
    repeat (2)  add(1'b1, 5'b00000);
    repeat (5)  add(1'b0, 5'b00000);
    add(1'b0, 5'b11000);
    repeat (10) add(1'b0, 5'b10000);
    repeat (5)  add(1'b1, 5'b10000);
    add(1'b1, 5'b00110);
    repeat (3)  add(1'b1, 5'b00000);
    foreach (vecs[i]) begin
      step(vecs[i].btn);
      check($sformatf("vec%0d", i), int'(outs()), int'(vecs[i].exp));
    end

    // Bounce on press, then a long hold.
    clr_log();
    repeat (3) step(1'b0);
    step(1'b1);
    c0 = cyc + 1;
    repeat (5) step(1'b0);
    check("bounce_no_early_press", n_press, 0);
    step(1'b0);
    check("bounce_press_at", t_press, c0 + 5);
    p0 = t_press;
    repeat (39) step(1'b0);
    check("long_count", n_long, 1);
    check("long_at", t_long, p0 + LP);
    r0 = cyc + 1;
    repeat (8) step(1'b1);
    check("long_release_at", t_release, r0 + 5);
    check("long_release_count", n_release, 1);
    check("long_no_short", n_short, 0);
    check("long_level_after", int'(bi.btn_level), 0);
    check("long_single_press", n_press, 1);

    // Release bounce at hold count 12.
    clr_log();
    c0 = cyc + 1;
    repeat (6) step(1'b0);
    check("rb_press_at", t_press, c0 + 5);
    p0 = t_press;
    repeat (10) step(1'b0);
    repeat (2)  step(1'b1);
    repeat (18) step(1'b0);
    check("rb_no_release", n_release, 0);
    check("rb_long_count", n_long, 1);
    check("rb_long_at", t_long, p0 + LP + 2);
    check("rb_level_held", int'(bi.btn_level), 1);
    repeat (8) step(1'b1);
    check("rb_release_count", n_release, 1);
    check("rb_no_short", n_short, 0);

    // Reset at hold count 15 with the button still low.
    clr_log();
    c0 = cyc + 1;
    repeat (6) step(1'b0);
    check("rst_press_at", t_press, c0 + 5);
    repeat (15) step(1'b0);
    check("rst_level_before", int'(bi.btn_level), 1);
    rst_n = 1'b0;
    #1;
    check("rst_async_outs", int'(outs()), 0);
    repeat (3) step(1'b0);
    check("rst_held_outs", int'(outs()), 0);
    rst_n = 1'b1;
    clr_log();
    c0 = cyc + 1;
    repeat (5) step(1'b0);
    check("rst_no_early_pulse", n_press + n_long, 0);
    repeat (25) step(1'b0);
    check("rst_repress_at", t_press, c0 + 5);
    check("rst_repress_count", n_press, 1);
    check("rst_long_at", t_long, c0 + 5 + LP);
    check("rst_long_count", n_long, 1);
    repeat (8) step(1'b1);
    check("rst_release_count", n_release, 1);
    check("rst_no_short", n_short, 0);

    check("no_back_to_back", n_b2b, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/usr_btn_debounce.md
USR_BTN_DEBOUNCE -- requirements
Module: usr_btn_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 480000 (10 ms at 48 MHz), the required number of consecutive stable samples, legal range 2..2^27-1.
REQ-002 SHALL have parameter LONG_PRESS_CYCLES, default 96000000 (2 s at 48 MHz), the hold time from debounced press to long-press event; must be greater than DEBOUNCE_CYCLES and at most 2^27-1.
REQ-003 Port clk: input, 1 bit, the single 48 MHz clock; all logic is on its rising edge.
REQ-004 Port rst_n: input, 1 bit, asynchronous active-low reset.
REQ-005 Port usr_btn: input, 1 bit, raw button (asynchronous, bouncy, 0 = pressed).
REQ-006 Port btn_level: output, 1 bit, debounced level (1 = pressed).
REQ-007 Port press_pulse: output, 1 bit, one-cycle strobe on a confirmed press.
REQ-008 Port release_pulse: output, 1 bit, one-cycle strobe on a confirmed release.
REQ-009 Port short_press: output, 1 bit, one-cycle strobe on a release that ends a hold shorter than LONG_PRESS_CYCLES.
REQ-010 Port long_press: output, 1 bit, one-cycle strobe when the hold reaches LONG_PRESS_CYCLES; this output drives the board-reset request.

Function
REQ-011 usr_btn SHALL pass through a 2-flop synchronizer; both flops SHALL reset to 1 (released); the FSM uses only the second flop (btn_s).
REQ-012 The FSM SHALL have the states RELEASED, PRESS_WAIT, PRESSED, LONG_HELD, and RELEASE_WAIT.
REQ-013 RELEASED with btn_s=0 SHALL go to PRESS_WAIT and clear the debounce counter.
REQ-014 In PRESS_WAIT, btn_s=1 on any cycle SHALL return the FSM to RELEASED with no output activity (glitch rejected).
REQ-015 In PRESS_WAIT, DEBOUNCE_CYCLES consecutive btn_s=0 samples SHALL move the FSM to PRESSED.
REQ-016 On entry to PRESSED, the block SHALL pulse press_pulse, set btn_level=1, and clear the hold counter.
REQ-017 Latency: with usr_btn held low, press_pulse SHALL assert exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples usr_btn low.
REQ-018 In PRESSED, the hold counter SHALL increment each cycle.
REQ-019 When the hold count reaches LONG_PRESS_CYCLES edges after press_pulse, the FSM SHALL enter LONG_HELD and pulse long_press once.
REQ-020 The hold counter SHALL saturate, never wrap, and long_press SHALL never re-fire within one hold.
REQ-021 PRESSED or LONG_HELD with btn_s=1 SHALL go to RELEASE_WAIT, remember the origin state, and freeze the hold counter.
REQ-022 In RELEASE_WAIT, btn_s=0 on any cycle SHALL return the FSM to the origin state with the hold counter resuming from its frozen value.
REQ-023 In RELEASE_WAIT, DEBOUNCE_CYCLES consecutive btn_s=1 samples SHALL move the FSM to RELEASED, pulse release_pulse, and clear btn_level.
REQ-024 On that confirmed release, short_press SHALL pulse in the same cycle as release_pulse only if the origin state was PRESSED.
REQ-025 press_pulse, release_pulse, short_press, and long_press SHALL be registered, one cycle wide, and never asserted on consecutive cycles.
REQ-026 The debounce counter SHALL be 27 bits wide.
REQ-027 The hold counter SHALL be 27 bits wide.
REQ-028 Counter compares SHALL be against the parameter values minus 1, with no off-by-one in the REQ-017 and REQ-019 latencies.

Reset
REQ-029 rst_n=0 SHALL immediately force state RELEASED, both counters to 0, the synchronizer flops to 1, and all outputs to 0, including mid-press and mid-debounce.
REQ-030 After rst_n is released with usr_btn already held low, the block SHALL perform a full fresh debounce and emit press_pulse per REQ-017, never long_press without a preceding press_pulse.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20)
REQ-031 Clean press: usr_btn 1->0 held -> press_pulse high for 1 cycle at edge 6 and btn_level=1 from edge 6.
REQ-032 Bounce on press: usr_btn low 3 cycles, high 1 cycle, then low held -> no pulse during the bounce; press_pulse 6 edges after the final fall.
REQ-033 Short press: hold low 10 cycles after press_pulse, then release -> release_pulse and short_press together 6 edges after the rise, no long_press, btn_level=0.
REQ-034 Long press: hold low 40 cycles -> long_press exactly once, 20 edges after press_pulse; on release, release_pulse only and short_press stays 0.
REQ-035 Release bounce: in PRESSED at hold count 12, usr_btn high 2 cycles then low -> no release_pulse, and long_press fires at hold count 20 counting only the low-sampled cycles.
REQ-036 Reset mid-hold: assert rst_n=0 at hold count 15 for 3 cycles with usr_btn still low -> outputs 0 immediately; after reset release, press_pulse again after 6 edges, then long_press 20 edges later.
